// File: rtl/encoder_pos_ctrl.sv
// rtl/encoder_pos_ctrl.sv - quadrature step sequencer: position, windowed velocity, homing, soft limits
module encoder_pos_ctrl #(
  parameter int POS_W   = 16,
  parameter int VEL_W   = 12,
  parameter int WIN_CYC = 1000,
  parameter int LIM_HI  = 32000,
  parameter int LIM_LO  = -32000,
  parameter int HOME_TO = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    plus1,
  input  logic                    minus1,
  input  logic                    index_in,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    cmd_home,
  input  logic                    clr_pos,
  input  logic                    clr_fault,
  output logic signed [POS_W-1:0] position,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid,
  output logic                    dir,
  output logic                    homed,
  output logic [1:0]              state,
  output logic [1:0]              fault_code,
  output logic                    both_err
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_TRACK  = 2'b01;
  localparam logic [1:0] ST_HOMING = 2'b10;
  localparam logic [1:0] ST_FAULT  = 2'b11;

  localparam int WIN_W = $clog2(WIN_CYC + 1);
  localparam int TO_W  = $clog2(HOME_TO + 1);

  localparam logic signed [POS_W-1:0] C_LIM_HI   = POS_W'(LIM_HI);
  localparam logic signed [POS_W-1:0] C_LIM_LO   = POS_W'(LIM_LO);
  localparam logic signed [VEL_W:0]   C_VMAX     = (VEL_W+1)'((2 ** (VEL_W - 1)) - 1);
  localparam logic signed [VEL_W:0]   C_VMIN     = -C_VMAX;
  localparam logic [WIN_W-1:0]        C_WIN_LAST = WIN_W'(WIN_CYC - 1);
  localparam logic [TO_W-1:0]         C_TO_LAST  = TO_W'(HOME_TO - 1);

  logic [1:0]              r_state;
  logic                    r_index_q;
  logic signed [POS_W-1:0] r_pos;
  logic                    r_dir;
  logic                    r_homed;
  logic [1:0]              r_fault_code;
  logic                    r_both_err;
  logic [WIN_W-1:0]        r_win_cnt;
  logic signed [VEL_W-1:0] r_delta;
  logic signed [VEL_W-1:0] r_vel;
  logic                    r_vel_valid;
  logic [TO_W-1:0]         r_to_cnt;

  logic [1:0]              w_next;
  logic                    w_active;
  logic                    w_up;
  logic                    w_dn;
  logic                    w_edge;
  logic                    w_hi_hit;
  logic                    w_lo_hit;
  logic                    w_lim;
  logic                    w_up_ok;
  logic                    w_dn_ok;
  logic                    w_to_exp;
  logic signed [VEL_W:0]   w_dstep;
  logic signed [VEL_W:0]   w_sum;
  logic signed [VEL_W-1:0] w_delta_sat;
  logic [1:0]              w_fc_nxt;
  logic                    w_homed_nxt;

  assign w_active = (r_state == ST_TRACK) || (r_state == ST_HOMING);
  assign w_up     = w_active & plus1 & ~minus1;
  assign w_dn     = w_active & minus1 & ~plus1;
  assign w_edge   = (r_state == ST_HOMING) & index_in & ~r_index_q;

  // The index edge zeroes position anyway, so no limit can be crossed on that cycle
  assign w_hi_hit = w_up & ~w_edge & (r_pos >= C_LIM_HI);
  assign w_lo_hit = w_dn & ~w_edge & (r_pos <= C_LIM_LO);
  assign w_lim    = w_hi_hit | w_lo_hit;
  assign w_up_ok  = w_up & ~w_lim;
  assign w_dn_ok  = w_dn & ~w_lim;
  assign w_to_exp = (r_state == ST_HOMING) && (r_to_cnt == C_TO_LAST);

  assign w_dstep = w_up_ok ? (VEL_W+1)'(1) : (w_dn_ok ? '1 : '0);
  assign w_sum   = {r_delta[VEL_W-1], r_delta} + w_dstep;

  always_comb begin
    w_delta_sat = w_sum[VEL_W-1:0];
    if (w_sum > C_VMAX) begin
      w_delta_sat = C_VMAX[VEL_W-1:0];
    end else if (w_sum < C_VMIN) begin
      w_delta_sat = C_VMIN[VEL_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_home) begin
          w_next = ST_HOMING;
        end else if (start) begin
          w_next = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (w_lim) begin
          w_next = ST_FAULT;
        end else if (stop) begin
          w_next = ST_IDLE;
        end else if (cmd_home) begin
          w_next = ST_HOMING;
        end
      end
      ST_HOMING: begin
        if (w_edge) begin
          w_next = ST_TRACK;
        end else if (w_lim) begin
          w_next = ST_FAULT;
        end else if (stop) begin
          w_next = ST_IDLE;
        end else if (w_to_exp) begin
          w_next = ST_FAULT;
        end
      end
      default: begin
        if (clr_fault) begin
          w_next = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_fc_nxt    = r_fault_code;
    w_homed_nxt = r_homed;
    if ((r_state == ST_FAULT) && (w_next == ST_IDLE)) begin
      w_fc_nxt = 2'b00;
    end else if (w_hi_hit) begin
      w_fc_nxt = 2'b01;
    end else if (w_lo_hit) begin
      w_fc_nxt = 2'b10;
    end else if ((r_state == ST_HOMING) && (w_next == ST_FAULT)) begin
      w_fc_nxt    = 2'b11;
      w_homed_nxt = 1'b0;
    end
    if (w_edge) begin
      w_homed_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index_q    <= 1'b0;
      r_pos        <= '0;
      r_dir        <= 1'b0;
      r_homed      <= 1'b0;
      r_fault_code <= 2'b00;
      r_both_err   <= 1'b0;
      r_to_cnt     <= '0;
    end else begin
      r_index_q    <= index_in;
      r_homed      <= w_homed_nxt;
      r_fault_code <= w_fc_nxt;
      if ((r_state == ST_IDLE) && clr_pos) begin
        r_pos <= '0;
      end else if (w_edge) begin
        r_pos <= '0;
      end else if (w_up_ok) begin
        r_pos <= r_pos + POS_W'(1);
      end else if (w_dn_ok) begin
        r_pos <= r_pos - POS_W'(1);
      end
      if (w_up_ok | w_dn_ok) begin
        r_dir <= w_up_ok;
      end
      if ((r_state == ST_FAULT) && clr_fault) begin
        r_both_err <= 1'b0;
      end else if (w_active & plus1 & minus1) begin
        r_both_err <= 1'b1;
      end
      if ((r_state == ST_HOMING) && (w_next == ST_HOMING)) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  // Partial windows are discarded outside TRACK/HOMING; velocity keeps its last value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_cnt   <= '0;
      r_delta     <= '0;
      r_vel       <= '0;
      r_vel_valid <= 1'b0;
    end else if (w_active) begin
      if (r_win_cnt == C_WIN_LAST) begin
        r_win_cnt   <= '0;
        r_delta     <= '0;
        r_vel       <= w_delta_sat;
        r_vel_valid <= 1'b1;
      end else begin
        r_win_cnt   <= r_win_cnt + WIN_W'(1);
        r_delta     <= w_delta_sat;
        r_vel_valid <= 1'b0;
      end
    end else begin
      r_win_cnt   <= '0;
      r_delta     <= '0;
      r_vel_valid <= 1'b0;
    end
  end

  assign position   = r_pos;
  assign velocity   = r_vel;
  assign vel_valid  = r_vel_valid;
  assign dir        = r_dir;
  assign homed      = r_homed;
  assign state      = r_state;
  assign fault_code = r_fault_code;
  assign both_err   = r_both_err;

endmodule

// File: tb/tb_encoder_pos_ctrl.sv
// tb/tb_encoder_pos_ctrl.sv - directed plus randomized checks against a behavioural model
module tb_encoder_pos_ctrl;

  localparam int POS_W   = 16;
  localparam int VEL_W   = 4;
  localparam int WIN_CYC = 10;
  localparam int LIM_HI  = 20;
  localparam int LIM_LO  = -20;
  localparam int HOME_TO = 20;
  localparam int VMAX    = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic plus1 = 1'b0, minus1 = 1'b0, index_in = 1'b0;
  logic start = 1'b0, stop = 1'b0, cmd_home = 1'b0, clr_pos = 1'b0, clr_fault = 1'b0;
  logic signed [POS_W-1:0] position;
  logic signed [VEL_W-1:0] velocity;
  logic vel_valid, dir, homed, both_err;
  logic [1:0] state, fault_code;

  int n_cmp = 0;
  int n_bad = 0;

  int m_state, m_pos, m_vel, m_vvalid, m_dir, m_homed, m_fc, m_both;
  int m_win, m_delta, m_to, m_idx_prev;

  always #5 clk = ~clk;

  encoder_pos_ctrl #(
    .POS_W(POS_W), .VEL_W(VEL_W), .WIN_CYC(WIN_CYC),
    .LIM_HI(LIM_HI), .LIM_LO(LIM_LO), .HOME_TO(HOME_TO)
  ) dut (
    .clk(clk), .reset(reset), .plus1(plus1), .minus1(minus1), .index_in(index_in),
    .start(start), .stop(stop), .cmd_home(cmd_home), .clr_pos(clr_pos), .clr_fault(clr_fault),
    .position(position), .velocity(velocity), .vel_valid(vel_valid), .dir(dir),
    .homed(homed), .state(state), .fault_code(fault_code), .both_err(both_err)
  );

  function automatic int sat(input int v);
    if (v > VMAX) return VMAX;
    if (v < -VMAX) return -VMAX;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_vel = 0; m_vvalid = 0; m_dir = 0; m_homed = 0;
    m_fc = 0; m_both = 0; m_win = 0; m_delta = 0; m_to = 0; m_idx_prev = 0;
  endtask

  // One clock of the controller described as rules on integers
  task automatic model_step();
    int  sv, counted, ns;
    bit  active, edge_seen, lim, tofault;
    active    = (m_state == 1) || (m_state == 2);
    sv        = 0;
    if (active && plus1 && !minus1) sv = 1;
    if (active && minus1 && !plus1) sv = -1;
    edge_seen = (m_state == 2) && index_in && (m_idx_prev == 0);
    lim       = active && !edge_seen &&
                ((sv == 1 && m_pos + 1 > LIM_HI) || (sv == -1 && m_pos - 1 < LIM_LO));
    counted   = lim ? 0 : sv;
    tofault   = 0;
    ns        = m_state;
    case (m_state)
      0: begin
        if (cmd_home) ns = 2; else if (start) ns = 1;
        if (clr_pos) m_pos = 0;
      end
      1: if (lim) ns = 3; else if (stop) ns = 0; else if (cmd_home) ns = 2;
      2: begin
        if (edge_seen) ns = 1;
        else if (lim) ns = 3;
        else if (stop) ns = 0;
        else if (m_to + 1 == HOME_TO) begin ns = 3; tofault = 1; end
      end
      default: if (clr_fault) ns = 0;
    endcase
    if (active) begin
      if (plus1 && minus1) m_both = 1;
      if (counted != 0) m_dir = (counted > 0) ? 1 : 0;
      m_pos = edge_seen ? 0 : m_pos + counted;
      if (lim) m_fc = (sv > 0) ? 1 : 2;
      if (tofault) begin m_fc = 3; m_homed = 0; end
      if (edge_seen) m_homed = 1;
      m_vvalid = 0;
      m_delta  = sat(m_delta + counted);
      m_win    = m_win + 1;
      if (m_win == WIN_CYC) begin
        m_vel = m_delta; m_vvalid = 1; m_delta = 0; m_win = 0;
      end
    end else begin
      m_win = 0; m_delta = 0; m_vvalid = 0;
      if (m_state == 3 && clr_fault) begin m_fc = 0; m_both = 0; end
    end
    m_to       = (m_state == 2 && ns == 2) ? m_to + 1 : 0;
    m_state    = ns;
    m_idx_prev = index_in ? 1 : 0;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, {30'd0, state}, m_state);
    chk({tag, ".position"}, $signed(position), m_pos);
    chk({tag, ".velocity"}, $signed(velocity), m_vel);
    chk({tag, ".vel_valid"}, {31'd0, vel_valid}, m_vvalid);
    chk({tag, ".dir"}, {31'd0, dir}, m_dir);
    chk({tag, ".homed"}, {31'd0, homed}, m_homed);
    chk({tag, ".fault_code"}, {30'd0, fault_code}, m_fc);
    chk({tag, ".both_err"}, {31'd0, both_err}, m_both);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    plus1 = 0; minus1 = 0; start = 0; stop = 0; cmd_home = 0; clr_pos = 0; clr_fault = 0;
  endtask

  task automatic idle_ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1;
    #2;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    reset = 0;

    // Start and five spaced forward steps
    start = 1; tick("start");
    for (int i = 0; i < 5; i++) begin
      plus1 = 1; tick("fwd");
      idle_ticks("fwd_gap", 2);
    end
    chk("pos_after_5", $signed(position), 5);
    do_reset("mid_reset");

    // Velocity window: 4 forward, 1 reverse
    start = 1; tick("vel_start");
    plus1 = 1; tick("vel");
    plus1 = 1; tick("vel");
    minus1 = 1; tick("vel");
    plus1 = 1; tick("vel");
    plus1 = 1; tick("vel");
    idle_ticks("vel_wait", 5);
    chk("vel_window", $signed(velocity), 3);
    // Saturation: every cycle of a window steps forward
    for (int i = 0; i < WIN_CYC; i++) begin plus1 = 1; tick("vel_sat"); end
    chk("vel_sat_val", $signed(velocity), VMAX);

    // Upper limit fault, pulses ignored, clear
    for (int i = 0; i < 12; i++) begin plus1 = 1; tick("lim_hi"); end
    for (int i = 0; i < 3; i++) begin plus1 = 1; tick("lim_frozen"); end
    start = 1; cmd_home = 1; tick("fault_ignores");
    clr_fault = 1; tick("clr_fault");

    // Lower limit
    start = 1; tick("lo_start");
    for (int i = 0; i < 45; i++) begin minus1 = 1; tick("lim_lo"); end
    clr_fault = 1; tick("clr_fault_lo");

    // Homing from position 7 with an index edge
    clr_pos = 1; tick("clr_pos_idle");
    start = 1; tick("home_prep");
    for (int i = 0; i < 7; i++) begin plus1 = 1; tick("to7"); end
    cmd_home = 1; tick("cmd_home");
    minus1 = 1; tick("home_step");
    minus1 = 1; tick("home_step");
    index_in = 1; plus1 = 1; tick("index_edge");
    idle_ticks("after_home", 2);

    // Homing timeout with index stuck high
    cmd_home = 1; tick("home_again");
    idle_ticks("home_timeout", HOME_TO + 3);
    clr_fault = 1; tick("clr_timeout");
    index_in = 0;

    // Simultaneous pulses
    start = 1; tick("both_start");
    plus1 = 1; minus1 = 1; tick("both");
    plus1 = 1; tick("both_sticky");
    minus1 = 1; tick("both_sticky");

    // Command priorities and clr_pos gating
    stop = 1; tick("stop");
    start = 1; cmd_home = 1; tick("start_vs_home");
    stop = 1; tick("stop_homing");
    start = 1; tick("restart");
    stop = 1; cmd_home = 1; tick("stop_vs_home");
    start = 1; tick("restart2");
    plus1 = 1; tick("step");
    clr_pos = 1; tick("clr_pos_track");
    stop = 1; tick("stop2");
    clr_pos = 1; tick("clr_pos_idle2");

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      plus1     = ($urandom_range(99, 0) < 35);
      minus1    = ($urandom_range(99, 0) < 30);
      start     = ($urandom_range(99, 0) < 6);
      stop      = ($urandom_range(99, 0) < 2);
      cmd_home  = ($urandom_range(99, 0) < 2);
      clr_pos   = ($urandom_range(99, 0) < 4);
      clr_fault = ($urandom_range(99, 0) < 8);
      if ($urandom_range(99, 0) < 6) index_in = ~index_in;
      if ($urandom_range(999, 0) < 3) begin
        do_reset("rand_reset");
      end else begin
        tick("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/encoder_pos_ctrl.md
Name: encoder_pos_ctrl

Overview:
Sequencing controller for the quadrature encoder block. Consumes its one-cycle plus1/minus1 step pulses and maintains a signed position count and a windowed velocity. Runs a homing sequence against an index pulse and enforces soft travel limits. Sits between the encoder front-end and the motion/register interface.

Parameters:
POS_W, 16, signed position width
VEL_W, 12, signed velocity (counts per window) width
WIN_CYC, 1000, velocity window length in clk cycles (≥2)
LIM_HI, 32000, upper soft limit (signed, inclusive)
LIM_LO, -32000, lower soft limit (signed, inclusive)
HOME_TO, 100000, homing timeout in clk cycles

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-high; clears all state
plus1  input  1  encoder forward step pulse
minus1  input  1  encoder reverse step pulse
index_in  input  1  encoder index (Z) level, already synchronised
start  input  1  IDLE -> TRACK request (pulse)
stop  input  1  TRACK/HOMING -> IDLE request (pulse)
cmd_home  input  1  begin homing (pulse)
clr_pos  input  1  zero position (honoured in IDLE only)
clr_fault  input  1  FAULT -> IDLE (pulse)
position  output  POS_W  signed position
velocity  output  VEL_W  signed counts in last completed window
vel_valid  output  1  one-cycle strobe when velocity updates
dir  output  1  last step direction, 1 = plus
homed  output  1  set on successful homing
state  output  2  00 IDLE, 01 TRACK, 10 HOMING, 11 FAULT
fault_code  output  2  00 none, 01 upper limit, 10 lower limit, 11 home timeout
both_err  output  1  sticky: plus1 and minus1 seen together

Behaviour:
- Single clock; reset is asynchronous and active-high, port names clk and reset. On reset: state IDLE, position 0, velocity 0, vel_valid 0, dir 0, homed 0, fault_code 00, both_err 0, window/timeout counters 0. Reset mid-operation aborts any state immediately.
- Step decode (TRACK and HOMING only): plus1&!minus1 -> +1; minus1&!plus1 -> -1; both -> no step, both_err set (sticky, cleared only by reset or clr_fault). Position/dir update the cycle after the pulse (1-cycle latency). Pulses ignored in IDLE and FAULT.
- dir updates only on a legal step.
- Limits: if a +1 would make position > LIM_HI: position holds, state -> FAULT, fault_code 01. If a -1 would make position < LIM_LO: hold, FAULT, code 10. Reaching the limit value exactly is legal.
- IDLE: cmd_home -> HOMING (cmd_home beats start same cycle); else start -> TRACK; clr_pos zeroes position next cycle. clr_pos ignored in other states.
- TRACK: stop -> IDLE (stop beats cmd_home); cmd_home -> HOMING; else count.
- HOMING: counts steps as TRACK; timeout counter cleared on entry. Index rising edge (index_in=1, previous sample 0): position <= 0 (overrides that cycle's step), homed <= 1, -> TRACK. Index already high on entry is not an edge. Counter reaching HOME_TO cycles with no edge: -> FAULT, code 11, homed cleared. stop -> IDLE, homed unchanged. Limit fault applies during homing too.
- FAULT: position frozen; only clr_fault leaves -> IDLE, clears fault_code and both_err. start/cmd_home/stop ignored.
- Velocity: window counter runs in TRACK/HOMING, cleared in IDLE/FAULT (partial window discarded, velocity holds last value). Signed delta accumulates legal steps; saturates at ±(2^(VEL_W-1)-1). On the WIN_CYC-th cycle: velocity <= delta including that cycle's step, vel_valid pulses for 1 cycle, delta and counter restart at 0.
- Position homing reset to 0 does not affect velocity delta.

Test Plan:
- Reset then start, 5 plus1 pulses spaced 3 cycles -> position 5, dir 1, state 01; reset asserted mid-run -> all outputs 0 immediately, state 00.
- TRACK, WIN_CYC=10 (override), 4 plus1 and 1 minus1 within window -> vel_valid high exactly 10 cycles after entry, velocity 3.
- LIM_HI=3: 4 plus1 pulses -> position 3, state 11, fault_code 01; further pulses ignored; clr_fault -> state 00, fault_code 00, position 3.
- cmd_home from position 7, two minus1 then index 0->1 -> position 0 cycle after edge, homed 1, state 01; HOME_TO=20 with index stuck high -> state 11, fault_code 11.
- plus1 and minus1 same cycle -> position unchanged, both_err 1 and sticky across later legal steps.
- IDLE with start and cmd_home same cycle -> HOMING; TRACK with stop and cmd_home same cycle -> IDLE; clr_pos in TRACK ignored, in IDLE -> position 0.
